// File: rtl/capture_buf_ctrl.sv
// Triggered burst capture controller driving a single-port RAM, with request/valid readout.
// Optional pre-trigger capture enabled by defining CAPTURE_PRETRIG_EN.
module capture_buf_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_arm,
    input  logic                  i_abort,
    input  logic                  i_trig,
    input  logic                  i_sample_stb,
    input  logic [DATA_WIDTH-1:0] i_sample,
    input  logic                  i_rd_next,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_valid,
    output logic                  o_armed,
    output logic                  o_capturing,
    output logic                  o_done,
    output logic                  o_ram_en,
    output logic                  o_ram_we,
    output logic [DEPTH_LOG2-1:0] o_ram_addr,
    output logic [DATA_WIDTH-1:0] o_ram_di,
    input  logic [DATA_WIDTH-1:0] i_ram_do
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;
`ifdef CAPTURE_PRETRIG_EN
    localparam int POST_COUNT  = DEPTH / 2;
    localparam int FILL_TARGET = DEPTH / 2;
`else
    localparam int POST_COUNT  = DEPTH;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_stateNext;
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2-1:0] r_rptr;
    logic [CNT_W-1:0]      r_postCnt;
    logic                  r_rdValid;

    logic                  w_wrEn;
    logic                  w_rdEn;
    logic                  w_clearPtrs;
    logic                  w_trigAccept;
    logic                  w_trigReady;
    logic                  w_postWrite;
    logic                  w_enterDone;
    logic [CNT_W-1:0]      w_postInc;
    logic [DEPTH_LOG2-1:0] w_wptrInc;

`ifdef CAPTURE_PRETRIG_EN
    logic [DEPTH_LOG2-1:0] r_fillCnt;
    assign w_trigReady = (r_fillCnt == DEPTH_LOG2'(FILL_TARGET));
`else
    assign w_trigReady = 1'b1;
`endif

    assign w_postInc = r_postCnt + 1'b1;
    assign w_wptrInc = r_wptr + 1'b1;

    // Post-trigger writes are what count toward the burst length.
    assign w_postWrite = w_wrEn && ((r_state == S_CAPTURE) || w_trigAccept);
    assign w_enterDone = (w_stateNext == S_DONE) && (r_state != S_DONE);

    always_comb begin
        w_stateNext  = r_state;
        w_wrEn       = 1'b0;
        w_rdEn       = 1'b0;
        w_clearPtrs  = 1'b0;
        w_trigAccept = 1'b0;
        if (i_rst || i_abort) begin
            w_stateNext = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_arm) begin
                        w_stateNext = S_ARMED;
                        w_clearPtrs = 1'b1;
                    end
                end
                S_ARMED: begin
                    w_trigAccept = i_trig && w_trigReady;
`ifdef CAPTURE_PRETRIG_EN
                    w_wrEn = i_sample_stb;
`else
                    w_wrEn = i_sample_stb && i_trig;
`endif
                    if (w_trigAccept) begin
                        if (w_wrEn && (w_postInc == CNT_W'(POST_COUNT)))
                            w_stateNext = S_DONE;
                        else
                            w_stateNext = S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    w_wrEn = i_sample_stb;
                    if (w_wrEn && (w_postInc == CNT_W'(POST_COUNT)))
                        w_stateNext = S_DONE;
                end
                S_DONE: begin
                    if (i_arm) begin
                        w_stateNext = S_ARMED;
                        w_clearPtrs = 1'b1;
                    end else begin
                        w_rdEn = i_rd_next;
                    end
                end
                default: w_stateNext = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_postCnt <= '0;
            r_rdValid <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_rdValid <= w_rdEn;
            if (w_clearPtrs) begin
                r_wptr    <= '0;
                r_rptr    <= '0;
                r_postCnt <= '0;
            end else begin
                if (w_wrEn)
                    r_wptr <= w_wptrInc;
                if (w_postWrite)
                    r_postCnt <= w_postInc;
`ifdef CAPTURE_PRETRIG_EN
                // The slot after the last write holds the oldest pre-trigger sample.
                if (w_enterDone)
                    r_rptr <= w_wptrInc;
                else if (w_rdEn)
                    r_rptr <= r_rptr + 1'b1;
`else
                if (w_rdEn)
                    r_rptr <= r_rptr + 1'b1;
`endif
            end
        end
    end

`ifdef CAPTURE_PRETRIG_EN
    // Saturating count of pre-trigger writes since arm; gates trigger acceptance.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fillCnt <= '0;
        end else if (w_clearPtrs) begin
            r_fillCnt <= '0;
        end else if (w_wrEn && (r_state == S_ARMED) && !w_trigReady) begin
            r_fillCnt <= r_fillCnt + 1'b1;
        end
    end
`else
    logic w_unusedEnterDone;
    assign w_unusedEnterDone = w_enterDone;
`endif

    assign o_armed     = (r_state == S_ARMED);
    assign o_capturing = (r_state == S_CAPTURE);
    assign o_done      = (r_state == S_DONE);
    assign o_rd_valid  = r_rdValid;
    assign o_rd_data   = i_ram_do;
    assign o_ram_en    = w_wrEn || w_rdEn;
    assign o_ram_we    = w_wrEn;
    assign o_ram_addr  = w_rdEn ? r_rptr : r_wptr;
    assign o_ram_di    = i_sample;

endmodule

// File: tb/tb_capture_buf_ctrl.sv
// Directed testbench for capture_buf_ctrl with a behavioural single-port RAM attached.
// Define CAPTURE_PRETRIG_EN for both files to exercise the pre-trigger build.
module tb_capture_buf_ctrl;

    logic       clk;
    logic       rst;
    logic       arm;
    logic       abort;
    logic       trig;
    logic       sampleStb;
    logic [7:0] sample;
    logic       rdNext;
    logic [7:0] rdData;
    logic       rdValid;
    logic       armed;
    logic       capturing;
    logic       done;
    logic       ramEn;
    logic       ramWe;
    logic [3:0] ramAddr;
    logic [7:0] ramDi;
    logic [7:0] ramDo;
    logic [2:0] dutFlags;
    logic [7:0] ramMem [0:15];

    int testsRun    = 0;
    int testsFailed = 0;

    capture_buf_ctrl #(
        .DATA_WIDTH(8),
        .DEPTH_LOG2(4)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_arm       (arm),
        .i_abort     (abort),
        .i_trig      (trig),
        .i_sample_stb(sampleStb),
        .i_sample    (sample),
        .i_rd_next   (rdNext),
        .o_rd_data   (rdData),
        .o_rd_valid  (rdValid),
        .o_armed     (armed),
        .o_capturing (capturing),
        .o_done      (done),
        .o_ram_en    (ramEn),
        .o_ram_we    (ramWe),
        .o_ram_addr  (ramAddr),
        .o_ram_di    (ramDi),
        .i_ram_do    (ramDo)
    );

    assign dutFlags = {armed, capturing, done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM with registered read data.
    always @(posedge clk) begin
        if (ramEn) begin
            if (ramWe) ramMem[ramAddr] <= ramDi;
            ramDo <= ramMem[ramAddr];
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        rst = 1'b0; arm = 1'b0; abort = 1'b0; trig = 1'b0;
        sampleStb = 1'b0; sample = 8'h00; rdNext = 1'b0;
    endtask

    task automatic pulseArm();
        arm = 1'b1;
        cycle();
        arm = 1'b0;
    endtask

    // Trigger together with the first sample, then 15 more strobes separated by gap idle cycles.
    task automatic captureBurst(input logic [7:0] base, input int gap);
        trig = 1'b1; sampleStb = 1'b1; sample = base;
        cycle();
        trig = 1'b0; sampleStb = 1'b0;
        for (int k = 1; k < 16; k++) begin
            repeat (gap) cycle();
            sampleStb = 1'b1; sample = base + 8'(k);
            cycle();
            sampleStb = 1'b0;
        end
    endtask

    task automatic test_reset();
        clearInputs();
        rst = 1'b1; sampleStb = 1'b1; sample = 8'h55;
        #1;
        testsRun++; if (ramWe !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_we_blocked: got %b expected 0", ramWe); end
        cycle();
        rst = 1'b0;
        #1;
        testsRun++; if ({ramEn, ramWe} !== 2'b00) begin testsFailed++; $display("[TB] FAIL idle_strobe_dropped: got en/we %b expected 00", {ramEn, ramWe}); end
        testsRun++; if (dutFlags !== 3'b000) begin testsFailed++; $display("[TB] FAIL reset_flags: got %b expected 000", dutFlags); end
        testsRun++; if (rdValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_rd_valid: got %b expected 0", rdValid); end
        sampleStb = 1'b0;
        cycle();
    endtask

`ifndef CAPTURE_PRETRIG_EN
    task automatic test_basic_burst();
        logic [7:0] expData;
        pulseArm();
        testsRun++; if (dutFlags !== 3'b100) begin testsFailed++; $display("[TB] FAIL basic_armed: got %b expected 100", dutFlags); end
        trig = 1'b1; sampleStb = 1'b1; sample = 8'h00;
        #1;
        testsRun++; if ({ramEn, ramWe, ramAddr} !== 6'b11_0000) begin testsFailed++; $display("[TB] FAIL basic_first_write: got en/we/addr %b expected 110000", {ramEn, ramWe, ramAddr}); end
        captureBurst(8'h00, 0);
        testsRun++; if (dutFlags !== 3'b001) begin testsFailed++; $display("[TB] FAIL basic_done: got %b expected 001", dutFlags); end
        for (int i = 0; i < 17; i++) begin
            rdNext = 1'b1;
            #1;
            testsRun++; if ({ramEn, ramWe, ramAddr} !== {2'b10, 4'(i)}) begin testsFailed++; $display("[TB] FAIL basic_read_addr[%0d]: got en/we/addr %b expected %b", i, {ramEn, ramWe, ramAddr}, {2'b10, 4'(i)}); end
            cycle();
            expData = 8'(i % 16);
            testsRun++; if ({rdValid, rdData} !== {1'b1, expData}) begin testsFailed++; $display("[TB] FAIL basic_read_data[%0d]: got valid/data %b/%h expected 1/%h", i, rdValid, rdData, expData); end
        end
        rdNext = 1'b0;
        cycle();
        testsRun++; if (rdValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL basic_valid_drop: got %b expected 0", rdValid); end
    endtask

    task automatic test_gapped();
        logic [7:0] expData;
        sampleStb = 1'b1; sample = 8'hEE;
        #1;
        testsRun++; if (ramWe !== 1'b0) begin testsFailed++; $display("[TB] FAIL done_strobe_dropped: got %b expected 0", ramWe); end
        sampleStb = 1'b0;
        pulseArm();
        sampleStb = 1'b1; sample = 8'hEE;
        #1;
        testsRun++; if (ramWe !== 1'b0) begin testsFailed++; $display("[TB] FAIL armed_no_trig_dropped: got %b expected 0", ramWe); end
        cycle();
        sampleStb = 1'b0;
        captureBurst(8'h10, 2);
        testsRun++; if (dutFlags !== 3'b001) begin testsFailed++; $display("[TB] FAIL gapped_done: got %b expected 001", dutFlags); end
        for (int i = 0; i < 16; i++) begin
            rdNext = 1'b1;
            cycle();
            expData = 8'h10 + 8'(i);
            testsRun++; if ({rdValid, rdData} !== {1'b1, expData}) begin testsFailed++; $display("[TB] FAIL gapped_read[%0d]: got valid/data %b/%h expected 1/%h", i, rdValid, rdData, expData); end
        end
        rdNext = 1'b0;
        cycle();
    endtask

    task automatic test_abort_midcapture();
        logic [7:0] expData;
        pulseArm();
        trig = 1'b1;
        for (int k = 0; k < 5; k++) begin
            sampleStb = 1'b1; sample = 8'hA0 + 8'(k);
            cycle();
            trig = 1'b0;
        end
        abort = 1'b1; sample = 8'hA5;
        #1;
        testsRun++; if (ramWe !== 1'b0) begin testsFailed++; $display("[TB] FAIL abort_blocks_write: got %b expected 0", ramWe); end
        cycle();
        abort = 1'b0; sampleStb = 1'b0;
        testsRun++; if (dutFlags !== 3'b000) begin testsFailed++; $display("[TB] FAIL abort_idle: got %b expected 000", dutFlags); end
        pulseArm();
        trig = 1'b1; sampleStb = 1'b1; sample = 8'h30;
        #1;
        testsRun++; if ({ramWe, ramAddr} !== 5'b1_0000) begin testsFailed++; $display("[TB] FAIL abort_rearm_addr: got we/addr %b expected 10000", {ramWe, ramAddr}); end
        captureBurst(8'h30, 0);
        for (int i = 0; i < 16; i++) begin
            rdNext = 1'b1;
            cycle();
            expData = 8'h30 + 8'(i);
            testsRun++; if ({rdValid, rdData} !== {1'b1, expData}) begin testsFailed++; $display("[TB] FAIL abort_read[%0d]: got valid/data %b/%h expected 1/%h", i, rdValid, rdData, expData); end
        end
        rdNext = 1'b0;
        cycle();
    endtask

    task automatic test_reset_midcapture();
        logic [7:0] expData;
        rdNext = 1'b1; rst = 1'b1;
        #1;
        testsRun++; if (ramEn !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_blocks_read: got %b expected 0", ramEn); end
        cycle();
        rdNext = 1'b0; rst = 1'b0;
        testsRun++; if ({dutFlags, rdValid} !== 4'b0000) begin testsFailed++; $display("[TB] FAIL rst_done_state: got flags/valid %b expected 0000", {dutFlags, rdValid}); end
        pulseArm();
        trig = 1'b1;
        for (int k = 0; k < 5; k++) begin
            sampleStb = 1'b1; sample = 8'hB0 + 8'(k);
            cycle();
            trig = 1'b0;
        end
        sampleStb = 1'b0; rst = 1'b1;
        cycle();
        rst = 1'b0;
        testsRun++; if ({dutFlags, rdValid} !== 4'b0000) begin testsFailed++; $display("[TB] FAIL rst_mid_state: got flags/valid %b expected 0000", {dutFlags, rdValid}); end
        pulseArm();
        trig = 1'b1; sampleStb = 1'b1; sample = 8'h40;
        #1;
        testsRun++; if ({ramWe, ramAddr} !== 5'b1_0000) begin testsFailed++; $display("[TB] FAIL rst_rearm_addr: got we/addr %b expected 10000", {ramWe, ramAddr}); end
        captureBurst(8'h40, 0);
        rdNext = 1'b1;
        #1;
        testsRun++; if (ramAddr !== 4'h0) begin testsFailed++; $display("[TB] FAIL rst_first_read_addr: got %h expected 0", ramAddr); end
        for (int i = 0; i < 16; i++) begin
            rdNext = 1'b1;
            cycle();
            expData = 8'h40 + 8'(i);
            testsRun++; if ({rdValid, rdData} !== {1'b1, expData}) begin testsFailed++; $display("[TB] FAIL rst_read[%0d]: got valid/data %b/%h expected 1/%h", i, rdValid, rdData, expData); end
        end
        rdNext = 1'b0;
        cycle();
    endtask

    task automatic test_priority();
        logic [7:0] expData;
        rdNext = 1'b1;
        cycle();
        arm = 1'b1;
        #1;
        testsRun++; if (ramEn !== 1'b0) begin testsFailed++; $display("[TB] FAIL prio_arm_read_en: got %b expected 0", ramEn); end
        cycle();
        arm = 1'b0; rdNext = 1'b0;
        testsRun++; if ({dutFlags, rdValid} !== 4'b1000) begin testsFailed++; $display("[TB] FAIL prio_arm_wins: got flags/valid %b expected 1000", {dutFlags, rdValid}); end
        trig = 1'b1; sampleStb = 1'b1; sample = 8'h50;
        cycle();
        trig = 1'b0;
        for (int k = 1; k < 16; k++) begin
            sampleStb = 1'b1; sample = 8'h50 + 8'(k);
            arm = (k == 5);
            #1;
            if (k == 5) begin
                testsRun++; if ({ramWe, ramAddr} !== 5'b1_0101) begin testsFailed++; $display("[TB] FAIL prio_arm_in_capture_write: got we/addr %b expected 10101", {ramWe, ramAddr}); end
            end
            cycle();
            arm = 1'b0;
            if (k == 5) begin
                testsRun++; if (dutFlags !== 3'b010) begin testsFailed++; $display("[TB] FAIL prio_arm_ignored: got %b expected 010", dutFlags); end
            end
        end
        sampleStb = 1'b0;
        testsRun++; if (dutFlags !== 3'b001) begin testsFailed++; $display("[TB] FAIL prio_done: got %b expected 001", dutFlags); end
        rdNext = 1'b1;
        #1;
        testsRun++; if (ramAddr !== 4'h0) begin testsFailed++; $display("[TB] FAIL prio_rptr_cleared: got %h expected 0", ramAddr); end
        for (int i = 0; i < 16; i++) begin
            rdNext = 1'b1;
            cycle();
            expData = 8'h50 + 8'(i);
            testsRun++; if ({rdValid, rdData} !== {1'b1, expData}) begin testsFailed++; $display("[TB] FAIL prio_read[%0d]: got valid/data %b/%h expected 1/%h", i, rdValid, rdData, expData); end
        end
        rdNext = 1'b0;
        cycle();
    endtask

    task automatic test_abort_after_read();
        rdNext = 1'b1;
        cycle();
        rdNext = 1'b0; abort = 1'b1;
        #1;
        testsRun++; if ({rdValid, rdData} !== {1'b1, 8'h50}) begin testsFailed++; $display("[TB] FAIL abort_after_read_valid: got valid/data %b/%h expected 1/50", rdValid, rdData); end
        cycle();
        abort = 1'b0;
        testsRun++; if ({dutFlags, rdValid} !== 4'b0000) begin testsFailed++; $display("[TB] FAIL abort_after_read_idle: got flags/valid %b expected 0000", {dutFlags, rdValid}); end
    endtask
`else
    task automatic test_pretrig();
        logic [7:0] expData;
        pulseArm();
        for (int i = 0; i < 8'h28; i++) begin
            sampleStb = 1'b1; sample = 8'(i);
            trig = (i == 4) || (i == 8'h20);
            cycle();
            trig = 1'b0;
            if (i == 4) begin
                testsRun++; if (dutFlags !== 3'b100) begin testsFailed++; $display("[TB] FAIL pretrig_early_trig_ignored: got %b expected 100", dutFlags); end
            end
            if (i == 8'h20 || i == 8'h26) begin
                testsRun++; if (dutFlags !== 3'b010) begin testsFailed++; $display("[TB] FAIL pretrig_capturing[%h]: got %b expected 010", i, dutFlags); end
            end
        end
        sampleStb = 1'b0;
        testsRun++; if (dutFlags !== 3'b001) begin testsFailed++; $display("[TB] FAIL pretrig_done: got %b expected 001", dutFlags); end
        rdNext = 1'b1;
        #1;
        testsRun++; if (ramAddr !== 4'h8) begin testsFailed++; $display("[TB] FAIL pretrig_first_read_addr: got %h expected 8", ramAddr); end
        for (int i = 0; i < 16; i++) begin
            rdNext = 1'b1;
            cycle();
            expData = 8'h18 + 8'(i);
            testsRun++; if ({rdValid, rdData} !== {1'b1, expData}) begin testsFailed++; $display("[TB] FAIL pretrig_read[%0d]: got valid/data %b/%h expected 1/%h", i, rdValid, rdData, expData); end
        end
        rdNext = 1'b0;
        cycle();
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
`ifndef CAPTURE_PRETRIG_EN
        test_basic_burst();
        test_gapped();
        test_abort_midcapture();
        test_reset_midcapture();
        test_priority();
        test_abort_after_read();
`else
        test_pretrig();
`endif
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
